// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
//
// Request side  : req_valid, req_ready, req_write, req_size, req_signed,
//                 req_addr, req_wdata
// Response side : resp_valid, resp_rdata, resp_err
// Memory side   : mem_ren, mem_wen, mem_addr (word index), mem_wdata,
//                 mem_rdata (combinational read data)
//
// slave  : the load/store unit itself
// master : the CPU MEM stage together with the memory it fronts
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_ren, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_ren, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU MEM stage and a word-addressed data memory.
// Accepts byte/halfword/word loads and stores on byte addresses, issues
// single-cycle word reads/writes, extracts and extends sub-word load data and
// performs read-modify-write for sub-word stores. Misaligned, out-of-range
// and size-3 requests are answered with an error and never touch memory.
//
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : asynchronous, active-low
//   bus   : mem_access_unit_if.slave (request, response and memory port)
//
// Every memory-side output is a register or a decode of the state register,
// so there is no combinational path from the request inputs to memory.
module mem_access_unit #(
    parameter int ADDR_BITS = 12
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state_reg, state_next;

    // Request fields captured at accept
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  lane_reg;      // byte offset within the word
    logic [31:0] addr_reg;      // word index driven on mem_addr
    logic [31:0] wdata_reg;
    logic        err_reg;

    logic [31:0] merge_reg;     // read word with the store lane replaced
    logic [31:0] rdata_reg;     // extended load result

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane;
    logic [31:0] merged;
    logic [31:0] load_ext;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    assign req_err = (bus.req_size == 2'd3)
                  || ((bus.req_size == 2'd1) && bus.req_addr[0])
                  || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0))
                  || ((bus.req_addr >> ADDR_BITS) != 32'd0);

    // Per-lane view of the read word and the sub-word store merge. A lane is
    // replaced when it is the addressed byte, or belongs to the addressed half.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       sel;
        logic [7:0] src;

        assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
        assign sel = (size_reg == 2'd0) ? (lane_reg == LANE)
                                        : (lane_reg[1] == LANE[1]);
        assign src = ((size_reg == 2'd0) || !LANE[0]) ? wdata_reg[7:0]
                                                      : wdata_reg[15:8];
        assign merged[8*gi +: 8] = sel ? src : byte_lane[gi];
    end

    assign half_lane = lane_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_ext = bus.mem_rdata;
        case (size_reg)
            2'd0: load_ext = {{24{signed_reg & byte_lane[lane_reg][7]}}, byte_lane[lane_reg]};
            2'd1: load_ext = {{16{signed_reg & half_lane[15]}}, half_lane};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_next     = state_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.mem_ren    = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_wdata  = 32'd0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!bus.req_write) begin
                        state_next = READ;
                    end else if (bus.req_size == 2'd2) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            READ: begin
                bus.mem_ren = 1'b1;
                state_next  = RESP;
            end
            WRITE: begin
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = wdata_reg;
                state_next    = RESP;
            end
            RMW_RD: begin
                bus.mem_ren = 1'b1;
                state_next  = RMW_WR;
            end
            RMW_WR: begin
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = merge_reg;
                state_next    = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and data path. rdata_reg is cleared at every accept so
    // stores and errors respond with zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            size_reg   <= 2'd0;
            signed_reg <= 1'b0;
            lane_reg   <= 2'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
            merge_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
        end else begin
            if (accept) begin
                size_reg   <= bus.req_size;
                signed_reg <= bus.req_signed;
                lane_reg   <= bus.req_addr[1:0];
                addr_reg   <= {2'b00, bus.req_addr[31:2]};
                wdata_reg  <= bus.req_wdata;
                err_reg    <= req_err;
                rdata_reg  <= 32'd0;
            end
            if (state_reg == READ) begin
                rdata_reg <= load_ext;
            end
            if (state_reg == RMW_RD) begin
                merge_reg <= merged;
            end
        end
    end

    assign bus.resp_rdata = rdata_reg;
    assign bus.mem_addr   = addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// traffic checked against a transaction-level memory model.
module tb_mem_access_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_access_unit_if bus ();

    mem_access_unit #(.ADDR_BITS(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Memory behind the port: combinational read, write commits on negedge
    logic [31:0] mem [1024];
    logic        mem_clear;
    int          ren_count  = 0;
    int          wen_count  = 0;
    int          viol_count = 0;
    logic [31:0] last_ren_addr, last_wen_addr, last_wen_data;

    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

    always @(negedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
        if (bus.mem_ren) begin
            ren_count     <= ren_count + 1;
            last_ren_addr <= bus.mem_addr;
        end
        if (bus.mem_wen) begin
            wen_count     <= wen_count + 1;
            last_wen_addr <= bus.mem_addr;
            last_wen_data <= bus.mem_wdata;
        end
        if (bus.mem_ren && bus.mem_wen) viol_count <= viol_count + 1;
        if (!bus.mem_wen && (bus.mem_wdata != 32'd0)) viol_count <= viol_count + 1;
    end

    // Reference model: byte-addressed view of a word array
    logic [31:0] ref_mem [1024];

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
               ((size == 2'd2) && (addr[1:0] != 2'd0)) || (addr[31:12] != 20'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr);
        logic [31:0] w, v, sh;
        w  = ref_mem[addr[11:2]];
        sh = {27'd0, addr[1:0], 3'd0};
        v  = w >> sh;
        case (size)
            2'd0: begin v = v & 32'hFF;   if (sgn && v[7])  v = v | 32'hFFFFFF00; end
            2'd1: begin v = v & 32'hFFFF; if (sgn && v[15]) v = v | 32'hFFFF0000; end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        logic [31:0] w, mask, sh;
        w    = ref_mem[addr[11:2]];
        sh   = {27'd0, addr[1:0], 3'd0};
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        if (size == 2'd2) ref_mem[addr[11:2]] = wdata;
        else ref_mem[addr[11:2]] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
    endtask

    // One request: waits for ready, presents it for one accept edge, then
    // measures latency (edges from accept until resp_valid is seen high).
    task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int rens, output int wens);
        int r0, w0, guard;
        guard = 0;
        @(negedge clock);
        while (!bus.req_ready && guard < 20) begin @(negedge clock); guard++; end
        if (!bus.req_ready) begin
            n_total++;
            $display("FAIL ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        r0 = ren_count;
        w0 = wen_count;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        if (!bus.resp_valid) begin
            n_total++;
            $display("FAIL resp_timeout: resp_valid=%b required 1", bus.resp_valid);
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        rens  = ren_count - r0;
        wens  = wen_count - w0;
        if (wr && !model_err(size, addr)) model_store(size, addr, wdata);
        $display("txn wr=%0b size=%0d sgn=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d ren=%0d wen=%0d",
                 wr, size, sgn, addr, wdata, rdata, err, lat, rens, wens);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        mem_clear = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        #1;
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.req_ready); else n_pass++;
        n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b required 0", bus.resp_err); else n_pass++;
        n_total++; if (bus.resp_rdata !== 32'd0) $display("FAIL reset_resp_rdata: got %h required 0", bus.resp_rdata); else n_pass++;
        n_total++; if (bus.mem_ren !== 1'b0) $display("FAIL reset_ren: got %b required 0", bus.mem_ren); else n_pass++;
        n_total++; if (bus.mem_wen !== 1'b0) $display("FAIL reset_wen: got %b required 0", bus.mem_wen); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h required 0", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %h required 0", bus.mem_wdata); else n_pass++;
        repeat (2) @(negedge clock);
        #1;
        mem_clear = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_load_extend();
        logic [31:0] rd; logic er; int lat, rn, wn;
        do_req(1'b1, 2'd2, 1'b0, 32'h0000000C, 32'h8899AABB, rd, er, lat, rn, wn);
        n_total++; if (lat !== 2) $display("FAIL word_store_latency: got %0d required 2", lat); else n_pass++;
        do_req(1'b0, 2'd0, 1'b1, 32'h0000000D, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'hFFFFFFAA) $display("FAIL load_byte_signed: got %h required FFFFFFAA", rd); else n_pass++;
        n_total++; if (er !== 1'b0) $display("FAIL load_byte_signed_err: got %b required 0", er); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL load_latency: got %0d required 2", lat); else n_pass++;
        n_total++; if (rn !== 1) $display("FAIL load_ren_cycles: got %0d required 1", rn); else n_pass++;
        do_req(1'b0, 2'd0, 1'b0, 32'h0000000D, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'h000000AA) $display("FAIL load_byte_unsigned: got %h required 000000AA", rd); else n_pass++;
    endtask

    task automatic test_rmw_store();
        logic [31:0] rd; logic er; int lat, rn, wn;
        do_req(1'b1, 2'd1, 1'b0, 32'h0000000E, 32'h00001234, rd, er, lat, rn, wn);
        n_total++; if (lat !== 3) $display("FAIL rmw_latency: got %0d required 3", lat); else n_pass++;
        n_total++; if ((rn !== 1) || (wn !== 1)) $display("FAIL rmw_cycles: got ren=%0d wen=%0d required 1/1", rn, wn); else n_pass++;
        n_total++; if (last_ren_addr !== 32'd3) $display("FAIL rmw_ren_addr: got %h required 3", last_ren_addr); else n_pass++;
        n_total++; if (last_wen_addr !== 32'd3) $display("FAIL rmw_wen_addr: got %h required 3", last_wen_addr); else n_pass++;
        n_total++; if (last_wen_data !== 32'h1234AABB) $display("FAIL rmw_wdata: got %h required 1234AABB", last_wen_data); else n_pass++;
        n_total++; if (rd !== 32'd0) $display("FAIL store_rdata: got %h required 0", rd); else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000000C, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'h1234AABB) $display("FAIL rmw_readback: got %h required 1234AABB", rd); else n_pass++;
    endtask

    task automatic test_word_half();
        logic [31:0] rd; logic er; int lat, rn, wn;
        do_req(1'b1, 2'd2, 1'b0, 32'h00000010, 32'hDEADBEEF, rd, er, lat, rn, wn);
        n_total++; if ((rn !== 0) || (wn !== 1)) $display("FAIL word_store_cycles: got ren=%0d wen=%0d required 0/1", rn, wn); else n_pass++;
        do_req(1'b0, 2'd1, 1'b1, 32'h00000012, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'hFFFFDEAD) $display("FAIL load_half_signed: got %h required FFFFDEAD", rd); else n_pass++;
        do_req(1'b0, 2'd1, 1'b0, 32'h00000010, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'h0000BEEF) $display("FAIL load_half_unsigned: got %h required 0000BEEF", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, rn, wn;
        logic        e_wr   [5];
        logic [1:0]  e_size [5];
        logic [31:0] e_addr [5];
        e_wr[0] = 1'b0; e_size[0] = 2'd2; e_addr[0] = 32'h00000006;
        e_wr[1] = 1'b0; e_size[1] = 2'd1; e_addr[1] = 32'h00000003;
        e_wr[2] = 1'b0; e_size[2] = 2'd3; e_addr[2] = 32'h00000000;
        e_wr[3] = 1'b0; e_size[3] = 2'd2; e_addr[3] = 32'h00001000;
        e_wr[4] = 1'b1; e_size[4] = 2'd0; e_addr[4] = 32'h00002004;
        for (int i = 0; i < 5; i++) begin
            do_req(e_wr[i], e_size[i], 1'b1, e_addr[i], 32'hFFFFFFFF, rd, er, lat, rn, wn);
            n_total++; if (er !== 1'b1) $display("FAIL err_flag[%0d]: got %b required 1", i, er); else n_pass++;
            n_total++; if (rd !== 32'd0) $display("FAIL err_rdata[%0d]: got %h required 0", i, rd); else n_pass++;
            n_total++; if (lat !== 1) $display("FAIL err_latency[%0d]: got %0d required 1", i, lat); else n_pass++;
            n_total++; if ((rn !== 0) || (wn !== 0)) $display("FAIL err_mem_access[%0d]: got ren=%0d wen=%0d required 0/0", i, rn, wn); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic er; int lat, rn, wn, w0, guard;
        do_req(1'b1, 2'd2, 1'b0, 32'h00000020, 32'h11111111, rd, er, lat, rn, wn);
        guard = 0;
        @(negedge clock);
        while (!bus.req_ready && guard < 20) begin @(negedge clock); guard++; end
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h00000020;
        bus.req_wdata  = 32'h0000005A;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        n_total++; if (bus.mem_ren !== 1'b1) $display("FAIL rmw_rd_ren: got %b required 1", bus.mem_ren); else n_pass++;
        w0 = wen_count;
        #1;
        reset = 1'b0;
        #1;
        n_total++; if (bus.mem_ren !== 1'b0) $display("FAIL abort_ren: got %b required 0", bus.mem_ren); else n_pass++;
        n_total++; if (bus.mem_wen !== 1'b0) $display("FAIL abort_wen: got %b required 0", bus.mem_wen); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'd0) $display("FAIL abort_mem_addr: got %h required 0", bus.mem_addr); else n_pass++;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_total++; if (wen_count !== w0) $display("FAIL abort_no_wen: got %0d writes required %0d", wen_count, w0); else n_pass++;
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL release_ready: got %b required 1", bus.req_ready); else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, 32'h00000020, 32'h0, rd, er, lat, rn, wn);
        n_total++; if (rd !== 32'h11111111) $display("FAIL abort_mem_intact: got %h required 11111111", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, rn, wn;
        logic [31:0] addrs [3];
        int acc_cyc [3];
        int acc_idx, resp_idx, cyc, ready_hi, r0, extra, guard;
        logic accepting;
        addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h48;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = 0;
            do_req(1'b1, 2'd2, 1'b0, addrs[i], $urandom, rd, er, lat, rn, wn);
        end
        acc_idx = 0; resp_idx = 0; cyc = 0; ready_hi = 0; extra = 0; guard = 0;
        @(negedge clock);
        while (!bus.req_ready && guard < 20) begin @(negedge clock); guard++; end
        r0 = ren_count;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'($urandom);
        bus.req_addr   = addrs[0];
        while (resp_idx < 3 && cyc < 40) begin
            if (bus.resp_valid) begin
                n_total++;
                if (bus.resp_rdata !== ref_mem[addrs[resp_idx][11:2]])
                    $display("FAIL b2b_rdata[%0d]: got %h required %h", resp_idx, bus.resp_rdata, ref_mem[addrs[resp_idx][11:2]]);
                else n_pass++;
                resp_idx++;
            end
            if (bus.req_ready) ready_hi++;
            accepting = bus.req_ready && (acc_idx < 3);
            @(posedge clock);
            #1;
            if (accepting) begin
                acc_cyc[acc_idx] = cyc;
                acc_idx++;
                if (acc_idx < 3) bus.req_addr = addrs[acc_idx];
            end
            cyc++;
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (bus.resp_valid) extra++;
        end
        $display("txn back-to-back: accepts=%0d responses=%0d cycles=%0d", acc_idx, resp_idx, cyc);
        n_total++; if (resp_idx !== 3) $display("FAIL b2b_responses: got %0d required 3", resp_idx); else n_pass++;
        n_total++; if (extra !== 0) $display("FAIL b2b_extra_resp: got %0d required 0", extra); else n_pass++;
        n_total++; if (ready_hi !== 3) $display("FAIL b2b_ready_cycles: got %0d required 3", ready_hi); else n_pass++;
        n_total++; if (acc_cyc[1] - acc_cyc[0] !== 3) $display("FAIL b2b_spacing01: got %0d required 3", acc_cyc[1] - acc_cyc[0]); else n_pass++;
        n_total++; if (acc_cyc[2] - acc_cyc[1] !== 3) $display("FAIL b2b_spacing12: got %0d required 3", acc_cyc[2] - acc_cyc[1]); else n_pass++;
        n_total++; if (ren_count - r0 !== 3) $display("FAIL b2b_ren_cycles: got %0d required 3", ren_count - r0); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd; logic er, wr, sgn, exp_err;
        logic [1:0] size;
        int lat, rn, wn, r, exp_lat, exp_rn, exp_wn;
        for (int t = 0; t < 150; t++) begin
            r     = $urandom_range(0, 9);
            size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            wr    = 1'($urandom);
            sgn   = 1'($urandom);
            wdata = $urandom;
            addr  = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) addr = addr | (32'h00001000 << $urandom_range(0, 19));
            exp_err = model_err(size, addr);
            exp_rd  = (exp_err || wr) ? 32'd0 : model_load(size, sgn, addr);
            exp_lat = exp_err ? 1 : (wr && (size != 2'd2)) ? 3 : 2;
            exp_rn  = (exp_err || (wr && (size == 2'd2))) ? 0 : 1;
            exp_wn  = (exp_err || !wr) ? 0 : 1;
            do_req(wr, size, sgn, addr, wdata, rd, er, lat, rn, wn);
            n_total++; if (er !== exp_err) $display("FAIL rand_err[%0d]: got %b required %b", t, er, exp_err); else n_pass++;
            n_total++; if (rd !== exp_rd) $display("FAIL rand_rdata[%0d]: got %h required %h", t, rd, exp_rd); else n_pass++;
            n_total++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, exp_lat); else n_pass++;
            n_total++; if ((rn !== exp_rn) || (wn !== exp_wn)) $display("FAIL rand_mem_cycles[%0d]: got ren=%0d wen=%0d required %0d/%0d", t, rn, wn, exp_rn, exp_wn); else n_pass++;
            if (exp_rn == 1) begin
                n_total++;
                if (last_ren_addr !== {2'b00, addr[31:2]}) $display("FAIL rand_ren_addr[%0d]: got %h required %h", t, last_ren_addr, {2'b00, addr[31:2]});
                else n_pass++;
            end
        end
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            n_total++;
            if (mem[i] !== ref_mem[i]) $display("FAIL mem_contents[%0d]: got %h required %h", i, mem[i], ref_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_invariants();
        n_total++;
        if (viol_count !== 0) $display("FAIL port_invariants: got %0d violations required 0", viol_count);
        else n_pass++;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        test_reset();
        test_load_extend();
        test_rmw_store();
        test_word_half();
        test_errors();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the word-addressed data memory port: the load/store unit between the CPU MEM stage and the Memory block.
Accepts byte, halfword and word loads/stores on byte addresses and issues single-cycle ren/wen word accesses.
Performs extract plus sign/zero-extend for sub-word loads, and read-modify-write for sub-word stores.
Rejects misaligned and out-of-range accesses without touching memory.

Parameters:
ADDR_BITS, 12, number of valid byte-address bits; 1024 words; addr[31:ADDR_BITS] must be zero.

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (1 only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  load result, extended; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out of range, or size 3
mem_ren  output  1  memory read enable
mem_wen  output  1  memory write enable
mem_addr  output  32  word index = {2'b00, addr[31:2]}
mem_wdata  output  32  word to write
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset (async, reset=0):
  - state = IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0, taking effect immediately, including mid-operation.
  - An aborted RMW must never assert mem_wen.
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP. Outputs are registered or decoded from state only; there is no combinational path from req_* to mem_*.
- Accept: at a posedge with state=IDLE and req_valid=1, latch write, size, signed, addr and wdata. req_valid while not IDLE is ignored; the requester must hold the request.
- Error check at accept. The request errors if any of these hold:
  - size=3;
  - size=1 and addr[0]=1;
  - size=2 and addr[1:0]!=0;
  - addr[31:ADDR_BITS]!=0.
  - On error: go to RESP with err=1. No ren or wen is ever asserted.
- Transitions from IDLE:
  - Load: READ.
  - Word store: WRITE.
  - Byte/half store: RMW_RD.
- READ: mem_ren=1 for exactly one cycle. At the closing posedge, register the extracted, extended value into resp_rdata, then go to RESP.
- WRITE: mem_wen=1 and mem_wdata=wdata for exactly one cycle (memory commits on the negedge inside it), then go to RESP.
- RMW_RD: mem_ren=1 for one cycle; capture mem_rdata into a merge register; go to RMW_WR.
- RMW_WR: mem_wen=1 with mem_wdata = merged word, then go to RESP.
- RESP: resp_valid=1 for one cycle; then IDLE.
- Latency, counted from accept edge to resp_valid high:
  - error: 1 cycle;
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles.
  - Back-to-back throughput is one request per latency+1 cycles.
- Lane mapping is little-endian within the word:
  - byte lane k = bits [8k+7:8k], k = addr[1:0];
  - half lane = bits [15:0] if addr[1]=0, else [31:16].
- Merge: replace only the addressed lane with req_wdata[7:0] or [15:0]; all other bits are unchanged from the read word.
- Extension: signed byte/half replicates bit 7/15 into the upper bits; unsigned fills with zeros. Word loads ignore req_signed.
- Invariants:
  - mem_ren and mem_wen are never both 1.
  - mem_addr is held stable for the whole RMW (both cycles).
  - mem_wdata=0 whenever mem_wen=0.
  - resp_rdata=0 when resp_err=1 or for stores.

Test Plan:
- Preload word 3 = 0x8899AABB.
  - Load byte signed @0x0000000D -> after 2 cycles resp_rdata=0xFFFFFFAA, err=0.
  - Same load unsigned -> 0x000000AA.
- Store half 0x00001234 @0x0000000E over 0x8899AABB:
  - ren then wen on consecutive cycles, both with mem_addr=3, wen data 0x1234AABB;
  - resp_valid 3 cycles after accept.
  - Follow-up load word @0xC -> 0x1234AABB.
- Store word 0xDEADBEEF @0x10 then load half signed @0x12 -> 0xFFFFDEAD; load half unsigned @0x10 -> 0x0000BEEF.
- Errors, each -> resp_valid with err=1 one cycle after accept, rdata=0, ren/wen never asserted:
  - load word @0x6;
  - load half @0x3;
  - size=3;
  - load word @0x00001000.
- Async reset:
  - Assert reset=0 during RMW_RD of a byte store @0x20 (word 8 = 0x11111111) -> mem_ren drops immediately, no wen follows, word 8 still reads 0x11111111.
  - After release: req_ready=1.
- Hold req_valid=1 continuously with 3 back-to-back word loads -> exactly 3 responses, each ren a single cycle; req_ready low from accept until the cycle after resp_valid.
